// File: rtl/shift_seq_ctrl.sv
// Purpose: command-driven sequencer that loads a WIDTH-bit shift register and shifts it cmd_len bits over sout/sin.
// Latency: command accepted at edge k -> busy in cycles k+1..k+len, response valid in cycle k+len+1 (k+1 if rejected).
// Backpressure: one command in flight; cmd_ready only in IDLE, response held in DONE until rsp_ready.
module shift_seq_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_dir,
    input  logic [CNT_W-1:0] cmd_len,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             sin,
    output logic             sout,
    output logic             busy,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    state_t             state_q;
    logic [WIDTH-1:0]   shreg_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               dir_q;
    logic               err_q;
    logic [WIDTH-1:0]   shreg_d;
    logic               len_bad;

    // Zero or over-long lengths are answered immediately with an error.
    assign len_bad = (cmd_len == '0) || (cmd_len > MAX_LEN);

    // One-bit shift of the register in the stored direction, sin entering the vacated end.
    always_comb begin
        shreg_d = shreg_q;
        if (dir_q) begin
            shreg_d = {sin, shreg_q[WIDTH-1:1]};
        end else begin
            shreg_d = {shreg_q[WIDTH-2:0], sin};
        end
    end

    // Sequencer: accept command, shift cnt bits, hold the response until taken.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        shreg_q <= cmd_data;
                        dir_q   <= cmd_dir;
                        cnt_q   <= cmd_len;
                        err_q   <= len_bad;
                        state_q <= len_bad ? DONE : SHIFT;
                    end
                end
                SHIFT: begin
                    shreg_q <= shreg_d;
                    cnt_q   <= cnt_q - ONE;
                    if (cnt_q == ONE) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Handshake and status outputs decode straight from the registered state.
    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q == SHIFT);
    assign rsp_valid = (state_q == DONE);
    assign rsp_data  = shreg_q;
    assign rsp_err   = err_q;

    // Outgoing bit is the end of the register about to be shifted out; quiet outside SHIFT.
    assign sout = busy ? (dir_q ? shreg_q[0] : shreg_q[WIDTH-1]) : 1'b0;

endmodule
